// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: oversamples csn/sck/sdi on clk and serves
// RDID, RDSR, WREN, WRDI, READ and PP against an external byte-wide memory port.
//
// state  | meaning
// IDLE   | csn high, pins ignored
// CMD    | shifting in the opcode byte
// ADDR   | shifting in address bytes for READ / PP
// DOUT   | driving ID, status or read data on sdo_dq1
// DIN    | page-program data bytes become memory writes
// IGNORE | rest of the frame is discarded
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic              sck,
    input  logic              sdi_dq0,
    output logic              sdo_dq1,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    input  logic              mem_busy
);

    localparam int AB = (ADDR_W + 7) / 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DOUT   = 3'd3;
    localparam logic [2:0] S_DIN    = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;

    localparam logic [1:0] M_ID   = 2'd0;
    localparam logic [1:0] M_SR   = 2'd1;
    localparam logic [1:0] M_READ = 2'd2;

    logic [1:0]        r_csn_s, r_sck_s, r_sdi_s;
    logic              r_csn_q, r_sck_q;
    logic [2:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_shift_in;
    logic [7:0]        r_opcode;
    logic [3:0]        r_addr_cnt;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [7:0]        r_out_sh;
    logic [1:0]        r_mode;
    logic [1:0]        r_id_idx;
    logic              r_wel;
    logic              r_load;
    logic              r_wr_done;
    logic              r_sdo, r_sdo_oe;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd_en, r_mem_wr_en;
    logic [7:0]        r_mem_wr_data;

    logic              w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall, w_byte_done;
    logic [7:0]        w_byte, w_status, w_id_byte;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_q;
    assign w_sck_fall  = ~r_sck_s[1] & r_sck_q;
    assign w_csn_rise  = r_csn_s[1] & ~r_csn_q;
    assign w_csn_fall  = ~r_csn_s[1] & r_csn_q;
    assign w_byte      = {r_shift_in, r_sdi_s[1]};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_status    = {6'b0, r_wel, mem_busy};
    assign w_id_byte   = (r_id_idx == 2'd1) ? JEDEC_ID[15:8] :
                         (r_id_idx == 2'd2) ? JEDEC_ID[7:0]  : 8'h00;
    // Excess high bits of a non-byte-multiple address fall off the top here.
    assign w_addr_next = ADDR_W'({r_addr_sh, w_byte});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn_s       <= 2'b11;
            r_sck_s       <= 2'b00;
            r_sdi_s       <= 2'b00;
            r_csn_q       <= 1'b1;
            r_sck_q       <= 1'b0;
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift_in    <= 7'd0;
            r_opcode      <= 8'h00;
            r_addr_cnt    <= 4'd0;
            r_addr_sh     <= '0;
            r_out_sh      <= 8'hFF;
            r_mode        <= M_ID;
            r_id_idx      <= 2'd0;
            r_wel         <= 1'b0;
            r_load        <= 1'b0;
            r_wr_done     <= 1'b0;
            r_sdo         <= 1'b1;
            r_sdo_oe      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_data <= 8'h00;
        end else begin
            r_csn_s     <= {r_csn_s[0], csn};
            r_sck_s     <= {r_sck_s[0], sck};
            r_sdi_s     <= {r_sdi_s[0], sdi_dq0};
            r_csn_q     <= r_csn_s[1];
            r_sck_q     <= r_sck_s[1];
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_load      <= r_mem_rd_en;
            r_wr_done   <= 1'b0;
            if (r_load)
                r_out_sh <= mem_rd_data;
            // Address advances only after the write strobe has been seen with the old address.
            if (r_wr_done)
                r_mem_addr <= r_mem_addr + ADDR_W'(1);

            if (w_csn_rise) begin
                r_state  <= S_IDLE;
                r_sdo    <= 1'b1;
                r_sdo_oe <= 1'b0;
                r_opcode <= 8'h00;
                if (r_opcode == OP_PP)
                    r_wel <= 1'b0;
            end else if (w_csn_fall) begin
                r_state   <= S_CMD;
                r_bit_cnt <= 3'd0;
                r_opcode  <= 8'h00;
            end else if (r_state != S_IDLE) begin
                if (w_sck_rise) begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_shift_in <= w_byte[6:0];
                end
                if (w_sck_fall && r_state == S_DOUT) begin
                    r_sdo    <= r_out_sh[7];
                    r_out_sh <= {r_out_sh[6:0], 1'b1};
                end
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_opcode <= w_byte;
                            case (w_byte)
                                OP_RDID: begin
                                    r_state  <= S_DOUT;
                                    r_sdo_oe <= 1'b1;
                                    r_mode   <= M_ID;
                                    r_out_sh <= JEDEC_ID[23:16];
                                    r_id_idx <= 2'd1;
                                end
                                OP_RDSR: begin
                                    r_state  <= S_DOUT;
                                    r_sdo_oe <= 1'b1;
                                    r_mode   <= M_SR;
                                    r_out_sh <= w_status;
                                end
                                OP_WREN: begin
                                    r_wel   <= 1'b1;
                                    r_state <= S_IGNORE;
                                end
                                OP_WRDI: begin
                                    r_wel   <= 1'b0;
                                    r_state <= S_IGNORE;
                                end
                                OP_READ, OP_PP: begin
                                    r_state    <= S_ADDR;
                                    r_addr_cnt <= 4'd0;
                                end
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                        S_ADDR: begin
                            r_addr_sh  <= w_addr_next;
                            r_addr_cnt <= r_addr_cnt + 4'd1;
                            if (r_addr_cnt == 4'(AB - 1)) begin
                                r_mem_addr <= w_addr_next;
                                if (r_opcode == OP_READ) begin
                                    r_state     <= S_DOUT;
                                    r_sdo_oe    <= 1'b1;
                                    r_mode      <= M_READ;
                                    r_mem_rd_en <= 1'b1;
                                end else begin
                                    r_state <= S_DIN;
                                end
                            end
                        end
                        S_DOUT: begin
                            case (r_mode)
                                M_ID: begin
                                    r_out_sh <= w_id_byte;
                                    if (r_id_idx != 2'd3)
                                        r_id_idx <= r_id_idx + 2'd1;
                                end
                                M_SR: r_out_sh <= w_status;
                                default: begin
                                    r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                                    r_mem_rd_en <= 1'b1;
                                end
                            endcase
                        end
                        S_DIN: begin
                            r_mem_wr_data <= w_byte;
                            r_mem_wr_en   <= r_wel;
                            r_wr_done     <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sdo_dq1     = r_sdo;
    assign sdo_oe      = r_sdo_oe;
    assign mem_addr    = r_mem_addr;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: host tasks push expected sdo bytes and memory
// strobes into queues; monitor processes pop and compare as the DUT produces them.
module tb_spi_flash_responder;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csn = 1'b1;
    logic        sck = 1'b0;
    logic        sdi_dq0 = 1'b0;
    logic        sdo_dq1, sdo_oe;
    logic [23:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_rd_data = 8'h00;
    logic [7:0]  mem_wr_data;
    logic        mem_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_sdo_q[$];
    logic [7:0]  obs_sdo_q[$];
    logic [31:0] exp_wr_q[$];
    logic [23:0] exp_rd_q[$];

    spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4018)) dut (
        .clk(clk), .rst(rst), .csn(csn), .sck(sck), .sdi_dq0(sdi_dq0),
        .sdo_dq1(sdo_dq1), .sdo_oe(sdo_oe), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Memory model: mem[i] = i[7:0], one-cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory-port monitor
    initial forever begin
        @(negedge clk);
        if (!rst && mem_wr_en) begin
            if (exp_wr_q.size() == 0) check("unexpected_wr", {mem_addr, mem_wr_data}, 32'hFFFFFFFF);
            else check("mem_write", {mem_addr, mem_wr_data}, exp_wr_q.pop_front());
        end
        if (!rst && mem_rd_en) begin
            if (exp_rd_q.size() == 0) check("unexpected_rd", {8'h00, mem_addr}, 32'hFFFFFFFF);
            else check("mem_rd_addr", {8'h00, mem_addr}, {8'h00, exp_rd_q.pop_front()});
        end
    end

    // sdo byte monitor
    initial forever begin
        @(negedge clk);
        if (obs_sdo_q.size() > 0) begin
            if (exp_sdo_q.size() == 0) check("unexpected_sdo", {24'h0, obs_sdo_q.pop_front()}, 32'hFFFFFFFF);
            else check("sdo_byte", {24'h0, obs_sdo_q.pop_front()}, {24'h0, exp_sdo_q.pop_front()});
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before 500us");
        $fatal(1);
    end

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx, output logic oe_any, output logic oe_all);
        rx = 8'h00; oe_any = 1'b0; oe_all = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sdi_dq0 = tx[i];
            #HALF;
            rx[i]  = sdo_dq1;
            oe_any = oe_any | sdo_oe;
            oe_all = oe_all & sdo_oe;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx; logic oa, ol;
        xfer(tx, 8, rx, oa, ol);
    endtask

    task automatic rd(input logic [7:0] exp);
        logic [7:0] rx; logic oa, ol;
        exp_sdo_q.push_back(exp);
        xfer(8'h00, 8, rx, oa, ol);
        obs_sdo_q.push_back(rx);
        check("oe_in_dout", {31'h0, ol}, 32'h1);
    endtask

    task automatic cs_low();
        csn = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        csn = 1'b1;
        #(2 * HALF);
    endtask

    task automatic rdsr(input logic [7:0] exp);
        cs_low(); send(8'h05); rd(exp); cs_high();
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        cs_low(); send(op); cs_high();
    endtask

    initial begin
        logic [7:0] rx; logic oa, ol;
        #1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sdo", {31'h0, sdo_dq1}, 32'h1);
        check("rst_oe", {31'h0, sdo_oe}, 32'h0);
        check("rst_strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        check("rst_addr_data", {mem_addr, mem_wr_data}, 32'h0);
        rst = 1'b0;
        #(2 * HALF);

        // RDID
        cs_low();
        xfer(8'h9F, 8, rx, oa, ol);
        check("rdid_oe_during_opcode", {31'h0, oa}, 32'h0);
        rd(8'hEF); rd(8'h40); rd(8'h18); rd(8'h00);
        cs_high();
        check("oe_after_csn", {31'h0, sdo_oe}, 32'h0);
        check("sdo_after_csn", {31'h0, sdo_dq1}, 32'h1);

        // RDSR / WREN / WRDI with busy
        mem_busy = 1'b1;
        rdsr(8'h01);
        one_byte_cmd(8'h06);
        rdsr(8'h03);
        one_byte_cmd(8'h04);
        rdsr(8'h01);
        mem_busy = 1'b0;

        // READ across byte boundary
        exp_rd_q.push_back(24'h0000FE);
        exp_rd_q.push_back(24'h0000FF);
        exp_rd_q.push_back(24'h000100);
        exp_rd_q.push_back(24'h000101);
        cs_low();
        send(8'h03); send(8'h00); send(8'h00); send(8'hFE);
        rd(8'hFE); rd(8'hFF); rd(8'h00);
        cs_high();

        // PP with address wrap
        one_byte_cmd(8'h06);
        exp_wr_q.push_back({24'hFFFFFF, 8'hA5});
        exp_wr_q.push_back({24'h000000, 8'h5A});
        cs_low();
        send(8'h02); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hA5); send(8'h5A);
        cs_high();
        rdsr(8'h00);

        // PP without WREN
        cs_low();
        send(8'h02); send(8'h00); send(8'h00); send(8'h10); send(8'h77);
        cs_high();
        rdsr(8'h00);

        // PP aborted mid-byte
        one_byte_cmd(8'h06);
        rdsr(8'h02);
        cs_low();
        send(8'h02); send(8'h00); send(8'h00); send(8'h10);
        xfer(8'hC3, 3, rx, oa, ol);
        cs_high();
        rdsr(8'h00);

        // rst in the middle of a READ
        exp_rd_q.push_back(24'h000000);
        exp_rd_q.push_back(24'h000001);
        cs_low();
        send(8'h03); send(8'h00); send(8'h00); send(8'h00);
        rd(8'h00);
        xfer(8'h00, 3, rx, oa, ol);
        check("oe_before_rst", {31'h0, sdo_oe}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("oe_after_rst", {31'h0, sdo_oe}, 32'h0);
        check("sdo_after_rst", {31'h0, sdo_dq1}, 32'h1);
        check("addr_after_rst", {8'h0, mem_addr}, 32'h0);
        rst = 1'b0;
        csn = 1'b1;
        #(4 * HALF);
        rdsr(8'h00);

        #(4 * HALF);
        check("sdo_q_drained", exp_sdo_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
